regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_pkg.sv | 19 +
 rtl/wb_hold_reg.sv | 29 ++
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_wb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_hold_reg.sv
// One-entry holding register for an odd-pipe write deferred by a collision.
module wb_hold_reg #(
  parameter int ADDR_W = regfile_wb_pkg::ADDR_W,
  parameter int DATA_W = regfile_wb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] held_addr,
  output logic [DATA_W-1:0] held_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_addr <= '0;
      held_data <= '0;
    end else if (load) begin
      held_addr <= load_addr;
      held_data <= load_data;
    end else if (clear) begin
      held_addr <= '0;
      held_data <= '0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates even/odd pipe writebacks onto two register-file write ports,
// deferring the younger odd write by one cycle on a same-address collision.
module regfile_wb_arbiter #(
  parameter int ADDR_W = regfile_wb_pkg::ADDR_W,
  parameter int DATA_W = regfile_wb_pkg::DATA_W,
  parameter int CNT_W  = regfile_wb_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ep_valid,
  input  logic [ADDR_W-1:0] ep_addr,
  input  logic [DATA_W-1:0] ep_data,
  input  logic              op_valid,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_data,
  output logic              op_ready,
  output logic              wrt_en_ep,
  output logic [ADDR_W-1:0] rt_ep_address,
  output logic [DATA_W-1:0] wrt_data_ep,
  output logic              wrt_en_op,
  output logic [ADDR_W-1:0] rt_op_address,
  output logic [DATA_W-1:0] wrt_data_op,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);
  import regfile_wb_pkg::*;

  state_t            state;
  logic              collide;
  logic              supersede;
  logic [ADDR_W-1:0] held_addr;
  logic [DATA_W-1:0] held_data;

  assign collide   = (state == IDLE) && ep_valid && op_valid && (ep_addr == op_addr);
  assign supersede = (state == HOLD) && ep_valid && (ep_addr == held_addr);

  wb_hold_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (collide),
    .clear     (state == HOLD),
    .load_addr (op_addr),
    .load_data (op_data),
    .held_addr (held_addr),
    .held_data (held_data)
  );

  assign op_ready   = (state == IDLE);
  assign pend_valid = (state == HOLD);
  assign pend_addr  = held_addr;  // hold register is cleared whenever not in HOLD

  assign wrt_en_ep     = rst_n && ep_valid;
  assign rt_ep_address = ep_addr;
  assign wrt_data_ep   = ep_data;

  always_comb begin
    wrt_en_op     = 1'b0;
    rt_op_address = op_addr;
    wrt_data_op   = op_data;
    if (state == HOLD) begin
      rt_op_address = held_addr;
      wrt_data_op   = held_data;
      wrt_en_op     = rst_n && !supersede;
    end else begin
      wrt_en_op = rst_n && op_valid && !collide;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      conflict_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (collide) begin
            state <= HOLD;
            if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
          end
        end
        HOLD: begin
          state <= IDLE;
          if (supersede && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a two-port register-file model.
module tb_regfile_wb_arbiter;
  localparam int AW = 7;
  localparam int DW = 128;
  localparam int CW = 4;

  localparam logic [DW-1:0] DA = {4{32'hAAAA_0001}};
  localparam logic [DW-1:0] DA2 = {4{32'hA2A2_0002}};
  localparam logic [DW-1:0] DB = {4{32'hBBBB_0003}};
  localparam logic [DW-1:0] DC = {4{32'hCCCC_0004}};
  localparam logic [DW-1:0] DD = {4{32'hDDDD_0005}};
  localparam logic [DW-1:0] DE = {4{32'hEEEE_0006}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ep_valid, op_valid;
  logic [AW-1:0] ep_addr, op_addr;
  logic [DW-1:0] ep_data, op_data;
  logic          op_ready, wrt_en_ep, wrt_en_op, pend_valid;
  logic [AW-1:0] rt_ep_address, rt_op_address, pend_addr;
  logic [DW-1:0] wrt_data_ep, wrt_data_op;
  logic [CW-1:0] conflict_cnt, drop_cnt;

  logic [DW-1:0] rf [128];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ep_valid(ep_valid), .ep_addr(ep_addr), .ep_data(ep_data),
    .op_valid(op_valid), .op_addr(op_addr), .op_data(op_data),
    .op_ready(op_ready),
    .wrt_en_ep(wrt_en_ep), .rt_ep_address(rt_ep_address), .wrt_data_ep(wrt_data_ep),
    .wrt_en_op(wrt_en_op), .rt_op_address(rt_op_address), .wrt_data_op(wrt_data_op),
    .pend_valid(pend_valid), .pend_addr(pend_addr),
    .conflict_cnt(conflict_cnt), .drop_cnt(drop_cnt)
  );

  // Odd port applied last so it would win a same-address collision.
  always @(posedge clk) begin
    if (wrt_en_ep) rf[rt_ep_address] <= wrt_data_ep;
    if (wrt_en_op) rf[rt_op_address] <= wrt_data_op;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; combinational outputs are checked 1 ns later.
  task automatic drive(input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                       input logic ov, input logic [AW-1:0] oa, input logic [DW-1:0] od);
    @(negedge clk);
    ep_valid = ev; ep_addr = ea; ep_data = ed;
    op_valid = ov; op_addr = oa; op_data = od;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic no_same_addr(input string tag);
    chk(tag, {127'd0, wrt_en_ep && wrt_en_op && (rt_ep_address == rt_op_address)}, '0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rf[i] = '0;
    rst_n = 1'b0;
    drive(1'b1, 7'd3, DA, 1'b1, 7'd4, DB);
    chk("rst_en_ep", wrt_en_ep, 0);
    chk("rst_en_op", wrt_en_op, 0);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_pend_valid", pend_valid, 0);
    chk("rst_conflict", conflict_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Different addresses: both ports pass straight through.
    drive(1'b1, 7'd5, DA, 1'b1, 7'd9, DB);
    chk("pass_en_ep", wrt_en_ep, 1);
    chk("pass_en_op", wrt_en_op, 1);
    chk("pass_op_addr", rt_op_address, 9);
    chk("pass_op_data", wrt_data_op, DB);
    chk("pass_op_ready", op_ready, 1);
    idle();
    chk("pass_rf5", rf[5], DA);
    chk("pass_rf9", rf[9], DB);
    chk("pass_op_ready_after", op_ready, 1);
    chk("pass_conflict", conflict_cnt, 0);
    chk("pass_drop", drop_cnt, 0);

    // Same-address collision: odd write deferred by one cycle.
    drive(1'b1, 7'd5, DA2, 1'b1, 7'd5, DB);
    chk("col_en_ep", wrt_en_ep, 1);
    chk("col_en_op", wrt_en_op, 0);
    no_same_addr("col_same_addr");
    idle();
    chk("col_op_ready", op_ready, 0);
    chk("col_pend_valid", pend_valid, 1);
    chk("col_pend_addr", pend_addr, 5);
    chk("col_conflict", conflict_cnt, 1);
    chk("col_rf5_even", rf[5], DA2);
    chk("hold_en_op", wrt_en_op, 1);
    chk("hold_op_addr", rt_op_address, 5);
    chk("hold_op_data", wrt_data_op, DB);
    idle();
    chk("hold_rf5_odd", rf[5], DB);
    chk("hold_op_ready", op_ready, 1);
    chk("hold_pend_valid", pend_valid, 0);
    chk("hold_pend_addr", pend_addr, 0);

    // Held write superseded by a later even write to the same address.
    drive(1'b1, 7'd5, DA, 1'b1, 7'd5, DB);
    drive(1'b1, 7'd5, DC, 1'b0, '0, '0);
    chk("sup_en_op", wrt_en_op, 0);
    chk("sup_en_ep", wrt_en_ep, 1);
    idle();
    chk("sup_rf5", rf[5], DC);
    chk("sup_drop", drop_cnt, 1);
    chk("sup_conflict", conflict_cnt, 2);
    chk("sup_en_op_after", wrt_en_op, 0);

    // Held write plus unrelated even write; new odd request must wait.
    drive(1'b1, 7'd5, DA, 1'b1, 7'd5, DB);
    drive(1'b1, 7'd7, DD, 1'b1, 7'd11, DE);
    chk("dual_en_ep", wrt_en_ep, 1);
    chk("dual_en_op", wrt_en_op, 1);
    chk("dual_op_addr", rt_op_address, 5);
    chk("dual_op_ready", op_ready, 0);
    drive(1'b0, '0, '0, 1'b1, 7'd11, DE);
    chk("dual_rf7", rf[7], DD);
    chk("dual_rf5", rf[5], DB);
    chk("dual_rf11_not_yet", rf[11], 0);
    chk("dual_op_ready_back", op_ready, 1);
    chk("dual_new_op_addr", rt_op_address, 11);
    idle();
    chk("dual_rf11", rf[11], DE);
    chk("dual_conflict", conflict_cnt, 3);
    chk("dual_drop", drop_cnt, 1);

    // Reset in HOLD discards the held write.
    drive(1'b1, 7'd20, DA, 1'b1, 7'd20, DB);
    @(negedge clk);
    ep_valid = 1'b0; op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rsth_pend_valid", pend_valid, 0);
    chk("rsth_en_op", wrt_en_op, 0);
    chk("rsth_conflict", conflict_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rsth_en_op_release", wrt_en_op, 0);
    idle();
    chk("rsth_rf20", rf[20], DA);
    chk("rsth_drop", drop_cnt, 0);
    chk("rsth_op_ready", op_ready, 1);

    // Counter saturation: 2^CW + 3 collisions.
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      drive(1'b1, 7'd30, DA, 1'b1, 7'd30, DB);
      idle();
    end
    idle();
    chk("sat_conflict", conflict_cnt, {CW{1'b1}});
    chk("sat_drop", drop_cnt, 0);
    chk("sat_rf30", rf[30], DB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
